// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing one IOb slave port (the CLINT) among N_REQ requesters.
// Serialises transactions, routes read responses to their issuer and answers timed-out reads with an error.
module iob_clint_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          m_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]   m_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   m_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] m_wstrb_i,
    output logic [N_REQ-1:0]          m_ready_o,
    output logic [N_REQ-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic [N_REQ-1:0]          m_err_o,
    output logic                      s_avalid_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [DATA_W/8-1:0]       s_wstrb_o,
    input  logic                      s_ready_i,
    input  logic                      s_rvalid_i,
    input  logic [DATA_W-1:0]         s_rdata_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o
);
    localparam int OW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = DATA_W / 8;
    localparam logic [OW:0]   NR    = (OW+1)'(N_REQ);
    localparam logic [OW-1:0] LAST  = OW'(N_REQ - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t state, state_nxt;
    logic [OW-1:0] owner, owner_nxt, ptr, ptr_nxt, win, owner_inc;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [OW:0]   scan;
    logic          any_req, is_write, timeout;
    logic [N_REQ-1:0] owner_oh;

    logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [N_REQ-1:0][DATA_W-1:0] wdata_v;
    logic [N_REQ-1:0][SW-1:0]     wstrb_v;

    assign addr_v  = m_addr_i;
    assign wdata_v = m_wdata_i;
    assign wstrb_v = m_wstrb_i;

    // Scan from the farthest slot back to ptr so the last hit is the first set bit at or after ptr.
    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        scan    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, ptr} + (OW+1)'(i);
            if (scan >= NR) scan = scan - NR;
            if (m_avalid_i[scan[OW-1:0]]) begin
                win     = scan[OW-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign owner_inc = (owner == LAST) ? '0 : owner + OW'(1);
    assign is_write  = |wstrb_v[owner];
    assign timeout   = (tcnt == TLAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        tcnt_nxt  = tcnt;
        case (state)
            IDLE: if (any_req) begin
                owner_nxt = win;
                state_nxt = ADDR;
            end
            ADDR: begin
                // An abandoned request leaves the priority pointer where it was.
                if (!m_avalid_i[owner]) begin
                    state_nxt = IDLE;
                end else if (s_ready_i) begin
                    if (is_write) begin
                        ptr_nxt   = owner_inc;
                        state_nxt = IDLE;
                    end else begin
                        tcnt_nxt  = '0;
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (s_rvalid_i || timeout) begin
                    ptr_nxt   = owner_inc;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are masked during reset so an abandoned transaction produces no handshake.
    always_comb begin
        m_ready_o  = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = '0;
        s_avalid_o = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        grant_o    = '0;
        busy_o     = 1'b0;
        if (!rst_i) begin
            case (state)
                ADDR: begin
                    s_avalid_o = m_avalid_i[owner];
                    s_addr_o   = addr_v[owner];
                    s_wdata_o  = wdata_v[owner];
                    s_wstrb_o  = wstrb_v[owner];
                    m_ready_o  = s_ready_i ? owner_oh : '0;
                    grant_o    = owner_oh;
                    busy_o     = 1'b1;
                end
                RESP: begin
                    grant_o = owner_oh;
                    busy_o  = 1'b1;
                    if (s_rvalid_i) begin
                        m_rvalid_o = owner_oh;
                        m_rdata_o  = s_rdata_i;
                    end else if (timeout) begin
                        m_rvalid_o = owner_oh;
                        m_err_o    = owner_oh;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
